// File: rtl/eeprom_rsp.sv
// eeprom_rsp: device-side responder for the two-wire serial EEPROM link.
// Decodes START/STOP, control byte, word address and data bytes from an
// oversampled SCL/SDA pair, and stores/returns bytes in an internal array.
// SDA is open-drain: the responder only ever pulls it low or releases it.
module eeprom_rsp #(
    parameter int unsigned ADDR_W   = 11,
    parameter logic [3:0]  DEV_CODE = 4'b1010
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCL,
    inout  wire               SDA,
    output logic              BUSY,
    output logic              WR_PULSE,
    output logic              RD_PULSE,
    output logic [ADDR_W-1:0] CUR_ADDR
);

    typedef enum logic [3:0] {
        IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK,
        WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t              state, state_n;
    logic [2:0]          scl_sr, sda_sr;
    logic                scl_s, scl_h, sda_s, sda_h;
    logic                scl_rise, scl_fall, start, stop;
    logic [3:0]          cnt, cnt_n;
    logic [7:0]          sh, sh_n;
    logic [7:0]          tx, tx_n;
    logic [ADDR_W-9:0]   hi_addr, hi_n;
    logic                rw, rw_n;
    logic                sda_oe, oe_n;
    logic                busy_n;
    logic [ADDR_W-1:0]   addr_n, addr_inc;
    logic                ack_seen, ack_n;
    logic                mem_we, rd_n;
    logic [7:0]          rd_cur, rd_nxt;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    // Two synchronizer stages plus one history stage; idle bus is high.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            scl_sr <= 3'b111;
            sda_sr <= 3'b111;
        end else begin
            scl_sr <= {scl_sr[1:0], SCL};
            sda_sr <= {sda_sr[1:0], SDA};
        end
    end

    assign scl_s    = scl_sr[1];
    assign scl_h    = scl_sr[2];
    assign sda_s    = sda_sr[1];
    assign sda_h    = sda_sr[2];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    // SCL must be high on both samples so an edge coinciding with an SCL
    // transition is never mistaken for a bus condition.
    assign start    = scl_s & scl_h & sda_h & ~sda_s;
    assign stop     = scl_s & scl_h & ~sda_h & sda_s;

    assign addr_inc = CUR_ADDR + ADDR_W'(1);
    assign rd_cur   = mem[CUR_ADDR];
    assign rd_nxt   = mem[addr_inc];

    // Array write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[CUR_ADDR] <= sh;
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            tx       <= '0;
            hi_addr  <= '0;
            rw       <= 1'b0;
            sda_oe   <= 1'b0;
            BUSY     <= 1'b0;
            CUR_ADDR <= '0;
            ack_seen <= 1'b0;
            WR_PULSE <= 1'b0;
            RD_PULSE <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sh       <= sh_n;
            tx       <= tx_n;
            hi_addr  <= hi_n;
            rw       <= rw_n;
            sda_oe   <= oe_n;
            BUSY     <= busy_n;
            CUR_ADDR <= addr_n;
            ack_seen <= ack_n;
            WR_PULSE <= mem_we;
            RD_PULSE <= rd_n;
        end
    end

    // Next-state and datapath decode; bus conditions override bit handling.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        tx_n    = tx;
        hi_n    = hi_addr;
        rw_n    = rw;
        oe_n    = sda_oe;
        busy_n  = BUSY;
        addr_n  = CUR_ADDR;
        ack_n   = ack_seen;
        mem_we  = 1'b0;
        rd_n    = 1'b0;
        if (start) begin
            state_n = CTRL;
            cnt_n   = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b1;
        end else if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                CTRL, ADDR, WDATA: begin
                    if (scl_rise && cnt < 4'd8) begin
                        sh_n  = {sh[6:0], sda_s};
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        cnt_n = '0;
                        if (state == CTRL) begin
                            if (sh[7:4] == DEV_CODE) begin
                                state_n = CTRL_ACK;
                                oe_n    = 1'b1;
                                hi_n    = sh[ADDR_W-8:1];
                                rw_n    = sh[0];
                            end else begin
                                state_n = IGNORE;
                            end
                        end else if (state == ADDR) begin
                            addr_n  = {hi_addr, sh};
                            oe_n    = 1'b1;
                            state_n = ADDR_ACK;
                        end else begin
                            mem_we  = 1'b1;
                            addr_n  = addr_inc;
                            oe_n    = 1'b1;
                            state_n = WDATA_ACK;
                        end
                    end
                end
                CTRL_ACK: begin
                    if (scl_fall) begin
                        if (rw) begin
                            // First read byte: put its MSB on the wire now.
                            oe_n    = ~rd_cur[7];
                            tx_n    = {rd_cur[6:0], 1'b0};
                            cnt_n   = 4'd1;
                            rd_n    = 1'b1;
                            state_n = RDATA;
                        end else begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = ADDR;
                        end
                    end
                end
                ADDR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = WDATA;
                    end
                end
                RDATA: begin
                    // cnt counts bits already placed on the wire.
                    if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            oe_n    = 1'b0;
                            ack_n   = 1'b0;
                            state_n = RACK;
                        end else begin
                            oe_n  = ~tx[7];
                            tx_n  = {tx[6:0], 1'b0};
                            cnt_n = cnt + 4'd1;
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            addr_n = addr_inc;
                            tx_n   = rd_nxt;
                            rd_n   = 1'b1;
                            ack_n  = 1'b1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end else if (scl_fall && ack_seen) begin
                        oe_n    = ~tx[7];
                        tx_n    = {tx[6:0], 1'b0};
                        cnt_n   = 4'd1;
                        ack_n   = 1'b0;
                        state_n = RDATA;
                    end
                end
                default: begin
                    // IDLE / IGNORE: bus released, waiting for START or STOP.
                    oe_n = 1'b0;
                end
            endcase
        end
    end

endmodule
